// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the thresholded synchronous FIFO: width arithmetic and
// parameter legality predicates evaluated at elaboration time by the top.
package sync_fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointers and the level output carry one extra wrap bit above the address.
  function automatic int level_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit af_thresh_ok(input int depth, input int th);
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit ae_thresh_ok(input int depth, input int th);
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array, no reset. Registered read port by default;
// asynchronous read when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic              re,
`endif
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = r_mem[raddr];
`else
  logic [WIDTH-1:0] r_q;

  // A same-address write in this edge is not forwarded: the head word is old data.
  always_ff @(posedge clk) begin
    if (re) r_q <= r_mem[raddr];
  end

  assign rdata = r_q;
`endif

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with watermark flags, level, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            clr_err,
  input  logic                            w_en,
  input  logic [FIFO_WIDTH-1:0]           data_write,
  input  logic                            r_en,
  output logic [FIFO_WIDTH-1:0]           data_read,
  output logic                            data_valid,
  output logic                            flag_full,
  output logic                            flag_empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [level_w(FIFO_DEPTH)-1:0]  level,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int ADDR_W = addr_w(FIFO_DEPTH);
  localparam int PTR_W  = level_w(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] AF_L    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_L    = PTR_W'(AE_THRESH);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("sync_fifo_thresh: FIFO_DEPTH must be a power of two >= 2");
  end
  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_thresh: FIFO_WIDTH must be >= 1");
  end
  if (!af_thresh_ok(FIFO_DEPTH, AF_THRESH)) begin : g_bad_af
    $error("sync_fifo_thresh: AF_THRESH out of range 1..FIFO_DEPTH");
  end
  if (!ae_thresh_ok(FIFO_DEPTH, AE_THRESH)) begin : g_bad_ae
    $error("sync_fifo_thresh: AE_THRESH out of range 0..FIFO_DEPTH-1");
  end

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [FIFO_WIDTH-1:0] w_ram_q;

  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_level == DEPTH_L);
  assign w_empty  = (w_level == '0);

  // A pop on a full FIFO frees the slot the push lands in during the same edge.
  assign w_rd_acc = r_en && !w_empty;
  assign w_wr_acc = w_en && (!w_full || w_rd_acc);

  // Flush discards any request made in its own cycle.
  assign w_ram_we  = w_wr_acc && !flush;
  assign w_ram_re  = w_rd_acc && !flush;
  assign w_ovf_set = w_en && !w_wr_acc && !flush;
  assign w_udf_set = r_en && !w_rd_acc && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_ram_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ram_re) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_udf_set)    r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wr_ptr[ADDR_W-1:0]),
    .wdata (data_write),
`ifndef SYNC_FIFO_FWFT_EN
    .re    (w_ram_re),
`endif
    .raddr (r_rd_ptr[ADDR_W-1:0]),
    .rdata (w_ram_q)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_valid = !w_empty;
  assign data_read  = w_empty ? '0 : w_ram_q;
`else
  logic r_data_valid;
  logic r_rd_started;

  // The RAM output register has no reset; mask it until the first real pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_valid <= 1'b0;
      r_rd_started <= 1'b0;
    end else begin
      r_data_valid <= w_ram_re;
      if (w_ram_re) r_rd_started <= 1'b1;
    end
  end

  assign data_valid = r_data_valid;
  assign data_read  = r_rd_started ? w_ram_q : '0;
`endif

  assign flag_full    = w_full;
  assign flag_empty   = w_empty;
  assign almost_full  = (w_level >= AF_L);
  assign almost_empty = (w_level <= AE_L);
  assign level        = w_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed self-checking bench for sync_fifo_thresh (WIDTH 8, DEPTH 16).
module tb_sync_fifo_thresh;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       w_en = 1'b0;
  logic [7:0] data_write = 8'h00;
  logic       r_en = 1'b0;
  logic [7:0] data_read;
  logic       data_valid;
  logic       flag_full;
  logic       flag_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int n_chk = 0;
  int n_err = 0;

  sync_fifo_thresh #(
    .FIFO_WIDTH (8),
    .FIFO_DEPTH (16),
    .AF_THRESH  (12),
    .AE_THRESH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .clr_err      (clr_err),
    .w_en         (w_en),
    .data_write   (data_write),
    .r_en         (r_en),
    .data_read    (data_read),
    .data_valid   (data_valid),
    .flag_full    (flag_full),
    .flag_empty   (flag_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply requests, let the edge act, sample 1ns after it.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    w_en = w;
    data_write = d;
    r_en = r;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    rst_n = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_empty", flag_empty, 1);
    chk("rst_full", flag_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_data", data_read, 0);

`ifdef SYNC_FIFO_FWFT_EN
    cyc(1, 8'h5C, 0);
    chk("fwft_dv", data_valid, 1);
    chk("fwft_data", data_read, 8'h5C);
    chk("fwft_level", level, 1);
    cyc(0, 8'h00, 1);
    chk("fwft_pop_empty", flag_empty, 1);
    chk("fwft_pop_dv", data_valid, 0);
`else
    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0);
      chk("fill_level", level, i + 1);
      chk("fill_full", flag_full, (i == 15) ? 1 : 0);
      chk("fill_af", almost_full, (i + 1 >= 12) ? 1 : 0);
      chk("fill_empty", flag_empty, 0);
    end
    cyc(1, 8'hEE, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    chk("ovf_full", flag_full, 1);
    chk("ovf_no_udf", underflow, 0);
    clr_err = 1'b1;
    cyc(0, 8'h00, 0);
    clr_err = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Drain in order
    for (int k = 0; k < 16; k++) begin
      cyc(0, 8'h00, 1);
      chk("drain_dv", data_valid, 1);
      chk("drain_data", data_read, k);
      chk("drain_level", level, 15 - k);
      chk("drain_ae", almost_empty, (15 - k <= 4) ? 1 : 0);
      chk("drain_empty", flag_empty, (k == 15) ? 1 : 0);
    end
    cyc(0, 8'h00, 0);
    chk("idle_dv", data_valid, 0);
    chk("idle_hold", data_read, 8'h0F);
    cyc(0, 8'h00, 1);
    chk("udf_set", underflow, 1);
    chk("udf_dv", data_valid, 0);
    chk("udf_level", level, 0);
    clr_err = 1'b1;
    cyc(0, 8'h00, 1);
    clr_err = 1'b0;
    chk("udf_set_beats_clr", underflow, 1);
    clr_err = 1'b1;
    cyc(0, 8'h00, 0);
    clr_err = 1'b0;
    chk("udf_clr", underflow, 0);

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0);
    chk("sim_full", flag_full, 1);
    cyc(1, 8'hAA, 1);
    chk("sim_level", level, 16);
    chk("sim_no_ovf", overflow, 0);
    chk("sim_dv", data_valid, 1);
    chk("sim_data", data_read, 8'h10);
    for (int k = 0; k < 15; k++) begin
      cyc(0, 8'h00, 1);
      chk("sim_drain", data_read, 8'h11 + k);
    end
    cyc(0, 8'h00, 1);
    chk("sim_aa", data_read, 8'hAA);
    chk("sim_empty", flag_empty, 1);

    // Empty with simultaneous write and read
    cyc(1, 8'h33, 1);
    chk("ewr_level", level, 1);
    chk("ewr_udf", underflow, 1);
    chk("ewr_dv", data_valid, 0);
    clr_err = 1'b1;
    cyc(0, 8'h00, 0);
    clr_err = 1'b0;
    cyc(0, 8'h00, 1);
    chk("ewr_data", data_read, 8'h33);
    chk("ewr_level0", level, 0);

    // Streaming across pointer wrap at level 3
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'h43 + i), 1);
      chk("wrap_data", data_read, 8'h40 + i);
      chk("wrap_level", level, 3);
      chk("wrap_dv", data_valid, 1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 1);
      chk("wrap_tail", data_read, 8'h68 + i);
    end
    chk("wrap_ovf", overflow, 0);
    chk("wrap_udf", underflow, 0);

    // Flush ignores same-cycle requests
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h80 + i), 0);
    chk("fl_pre_level", level, 7);
    flush = 1'b1;
    cyc(1, 8'hFF, 1);
    flush = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_empty", flag_empty, 1);
    chk("fl_dv", data_valid, 0);
    chk("fl_ovf", overflow, 0);
    chk("fl_udf", underflow, 0);
    cyc(1, 8'h77, 0);
    cyc(0, 8'h00, 1);
    chk("fl_after_data", data_read, 8'h77);
    chk("fl_after_level", level, 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h90 + i), 0);
    rst_n = 1'b0;
    cyc(1, 8'h99, 1);
    rst_n = 1'b1;
    chk("mrst_level", level, 0);
    chk("mrst_empty", flag_empty, 1);
    chk("mrst_dv", data_valid, 0);
    chk("mrst_data", data_read, 0);
    cyc(0, 8'h00, 1);
    chk("mrst_udf", underflow, 1);
    chk("mrst_rd_dv", data_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
